// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/monitor and the pwm_capture duty-cycle meter.
// The master drives the waveform and framing; the slave reports each completed measurement.
interface pwm_capture_if #(
  parameter int COUNT_BITS = 7
);
  logic                  pwm_in;
  logic                  frame_start;
  logic                  free_run;
  logic [COUNT_BITS-1:0] duty;
  logic                  duty_valid;
  logic                  saturated;
  logic                  restart_err;
  logic                  busy;

  modport master (
    output pwm_in, frame_start, free_run,
    input  duty, duty_valid, saturated, restart_err, busy
  );

  modport slave (
    input  pwm_in, frame_start, free_run,
    output duty, duty_valid, saturated, restart_err, busy
  );
endinterface

// File: rtl/pwm_capture.sv
// Duty-cycle meter for a motor PWM line: counts high cycles over a 2^COUNT_BITS-cycle
// window opened by frame_start and reports the count as an RPM-domain value.
module pwm_capture #(
  parameter int COUNT_BITS  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.slave  bus
);
  localparam int HiW = COUNT_BITS + 1;

  typedef enum logic [0:0] {
    IDLE,
    MEASURE
  } state_e;

  logic pwm_a;
  logic fs_a;

  // Both inputs see the same number of flops so a frame_start stays aligned with
  // the first PWM sample it marks.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign pwm_a = bus.pwm_in;
    assign fs_a  = bus.frame_start;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] pwm_sync_q;
    logic [SYNC_STAGES-1:0] fs_sync_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pwm_sync_q <= '0;
        fs_sync_q  <= '0;
      end else begin
        pwm_sync_q <= SYNC_STAGES'({pwm_sync_q, bus.pwm_in});
        fs_sync_q  <= SYNC_STAGES'({fs_sync_q, bus.frame_start});
      end
    end

    assign pwm_a = pwm_sync_q[SYNC_STAGES-1];
    assign fs_a  = fs_sync_q[SYNC_STAGES-1];
  end

  state_e                state_q;
  logic [COUNT_BITS-1:0] samp_q;
  logic [HiW-1:0]        hi_q;
  logic [COUNT_BITS-1:0] duty_q;
  logic                  saturated_q;
  logic                  duty_valid_q;
  logic                  restart_err_q;
  logic                  busy_q;

  logic [HiW-1:0]        hi_d;
  logic [HiW-1:0]        hi_first_d;
  logic [COUNT_BITS-1:0] duty_d;
  logic                  last_sample;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    hi_d        = hi_q + HiW'(pwm_a);
    hi_first_d  = HiW'(pwm_a);
    duty_d      = hi_d[COUNT_BITS] ? '1 : hi_d[COUNT_BITS-1:0];
    last_sample = (samp_q == {COUNT_BITS{1'b1}}) && !fs_a;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      samp_q        <= '0;
      hi_q          <= '0;
      duty_q        <= '0;
      saturated_q   <= 1'b0;
      duty_valid_q  <= 1'b0;
      restart_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      duty_valid_q  <= 1'b0;
      restart_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fs_a) begin
            state_q <= MEASURE;
            samp_q  <= COUNT_BITS'(1);
            hi_q    <= hi_first_d;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        MEASURE: begin
          busy_q <= 1'b1;
          if (fs_a) begin
            // A new frame mid-window discards the partial count; this edge is sample 0.
            restart_err_q <= 1'b1;
            samp_q        <= COUNT_BITS'(1);
            hi_q          <= hi_first_d;
          end else if (last_sample) begin
            duty_q       <= duty_d;
            saturated_q  <= hi_d[COUNT_BITS];
            duty_valid_q <= 1'b1;
            samp_q       <= '0;
            hi_q         <= '0;
            state_q      <= bus.free_run ? MEASURE : IDLE;
          end else begin
            samp_q <= samp_q + COUNT_BITS'(1);
            hi_q   <= hi_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.duty        = duty_q;
  assign bus.saturated   = saturated_q;
  assign bus.duty_valid  = duty_valid_q;
  assign bus.restart_err = restart_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle of a motor PWM waveform and reports it as an RPM-domain count. Each measurement window is 2^COUNT_BITS clock cycles. The block counts the high cycles in the window, so it is the receive-side counterpart of the motor `pwm` generator. It sits on the motor feedback / loopback path, where it checks that the commanded RPM value actually appears on the motor line.

## Interface

Parameters:
- COUNT_BITS, default 7: window length is 2^COUNT_BITS cycles; duty width is COUNT_BITS.
- SYNC_STAGES, default 2: flop stages applied to both pwm_in and frame_start. 0 means same-domain, with no delay.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- pwm_in, input, 1: PWM waveform under measurement.
- frame_start, input, 1: one-cycle pulse marking the first cycle of a PWM frame.
- free_run, input, 1: when 1, a new window starts back-to-back after each completed window without frame_start.
- duty, output, COUNT_BITS: high-cycle count of the last completed window, saturated to 2^COUNT_BITS-1.
- duty_valid, output, 1: one-cycle pulse when duty updates.
- saturated, output, 1: set when the last completed window was high for all 2^COUNT_BITS cycles; updates with duty.
- restart_err, output, 1: one-cycle pulse when a window is aborted by frame_start.
- busy, output, 1: 1 while in MEASURE.

## Operation

- Alignment: pwm_a and fs_a are pwm_in and frame_start delayed by exactly SYNC_STAGES flops. Both inputs get identical delay, so alignment is preserved. All sync flops reset to 0.
- Registers:
  - sample counter samp, COUNT_BITS wide, wraps naturally.
  - high counter hi, COUNT_BITS+1 wide.
- State IDLE:
  - If fs_a=1 at an edge: go to MEASURE. That edge is sample 0: samp<=1, hi<=pwm_a.
  - Otherwise stay; counters hold.
- State MEASURE, each edge:
  - If fs_a=1: abort the window and pulse restart_err. Restart as in IDLE, with this edge as sample 0. duty is unchanged and there is no duty_valid.
  - Otherwise: take the sample, with hi += pwm_a and samp += 1.
- Window completion: the edge where samp = 2^COUNT_BITS-1 and fs_a=0 is the last sample.
  - At that edge register duty = min(hi_final, 2^COUNT_BITS-1) and saturated = (hi_final == 2^COUNT_BITS). hi_final includes this last sample.
  - Assert duty_valid for the following cycle.
  - Next state: MEASURE if free_run=1, with the next edge as sample 0 and counters cleared. Otherwise IDLE.
- free_run is sampled only at the completion edge.
- Reset (any time, including mid-window):
  - state IDLE; samp=0, hi=0; duty=0, saturated=0; duty_valid=0, restart_err=0, busy=0.
  - The partial window is discarded; no duty_valid.

## Timing

- Reset values: all outputs 0.
- Latency, with s = SYNC_STAGES, N = COUNT_BITS, and frame_start high at raw edge t:
  - Samples cover pwm_in values at raw edges t .. t+2^N-1.
  - duty and duty_valid are visible in the cycle after edge t+s+2^N-1.
  - With s=0, N=7: valid in the cycle after edge 127.
- duty_valid and restart_err:
  - Each is high for exactly one cycle.
  - They are never high together: a completion and a restart cannot share an edge, because fs_a takes priority at the completion edge.
- busy is 1 from the cycle after the sample-0 edge up to and including the cycle in which duty_valid is high. In free_run it stays 1 continuously.
- Free-run back-to-back windows: duty_valid pulses every 2^N cycles with no gap samples.
- duty and saturated hold between updates.

## Test plan

- Generator loopback, s=2, N=7: drive a frame with 64 high cycles then 64 low, frame_start on the first cycle -> duty=64, saturated=0, one duty_valid pulse 2+127 edges after the frame_start edge.
- Extremes: duty 0 (pwm_in low all window) -> duty=0. Duty 127 -> duty=127, saturated=0. pwm_in high all 128 cycles -> duty=127, saturated=1.
- Sweep: loop the pwm generator for rpm 0..127 with frame_start = set -> duty equals rpm for every value, with 128 duty_valid pulses.
- Restart: frame_start again 50 cycles into a window -> restart_err pulses once, no duty_valid. The new window reports the duty of the second frame only.
- Reset mid-window: assert reset for one cycle at sample 70 -> all outputs 0 the next cycle, no duty_valid. The next frame_start measures correctly.
- Free run: free_run=1, one frame_start, constant 32/128 waveform -> duty_valid every 128 cycles, duty=32 each time, busy stays 1. Dropping free_run before a completion edge -> IDLE after that window.
